// File: rtl/intr_host_pkg.sv
// Shared types and default constants for the interrupt host master and its
// service sequencer.
package intr_host_pkg;

  localparam int INTR_ID_W      = 4;
  localparam int DEF_NUM_INTR   = 16;
  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_SVC_CYCLES = 4;

  typedef enum logic [1:0] {
    B_IDLE,
    B_SETUP,
    B_ACCESS,
    B_RESP
  } bus_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ACK,
    S_GAP
  } svc_state_e;

endpackage

// File: rtl/intr_svc_seq.sv
// Interrupt-service handshake: capture an ID, stay busy for SVC_CYCLES+1
// cycles, pulse the acknowledge, then hold off one cycle before the next capture.
module intr_svc_seq
  import intr_host_pkg::*;
#(
  parameter int SVC_CYCLES = DEF_SVC_CYCLES
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  input  logic                 intr_req_i,
  input  logic [INTR_ID_W-1:0] intr_to_service_i,
  output logic                 intr_serviced_o,
  output logic                 svc_active_o,
  output logic [INTR_ID_W-1:0] svc_id_o,
  output logic [15:0]          svc_count_o
);

  localparam int CNT_W = (SVC_CYCLES > 0) ? $clog2(SVC_CYCLES + 1) : 1;

  svc_state_e           svc_state, svc_next;
  logic [CNT_W-1:0]     svc_cnt, svc_cnt_d;
  logic [INTR_ID_W-1:0] svc_id_d;
  logic [15:0]          svc_count_d;
  logic                 intr_serviced_d;
  logic                 svc_active_d;

  // Countdown reaches 0 while busy, so the handler occupies SVC_CYCLES+1 cycles.
  always_comb begin
    svc_next    = svc_state;
    svc_cnt_d   = svc_cnt;
    svc_id_d    = svc_id_o;
    svc_count_d = svc_count_o;
    case (svc_state)
      S_IDLE: begin
        if (intr_req_i) begin
          svc_next  = S_BUSY;
          svc_cnt_d = CNT_W'(SVC_CYCLES);
          svc_id_d  = intr_to_service_i;
        end
      end
      S_BUSY: begin
        if (svc_cnt == '0) begin
          svc_next = S_ACK;
          if (svc_count_o != 16'hFFFF) svc_count_d = svc_count_o + 16'd1;
        end else begin
          svc_cnt_d = svc_cnt - CNT_W'(1);
        end
      end
      S_ACK:   svc_next = S_GAP;
      default: svc_next = S_IDLE;
    endcase
    intr_serviced_d = (svc_next == S_ACK);
    svc_active_d    = (svc_next == S_BUSY);
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      svc_state       <= S_IDLE;
      svc_cnt         <= '0;
      svc_id_o        <= '0;
      svc_count_o     <= '0;
      intr_serviced_o <= 1'b0;
      svc_active_o    <= 1'b0;
    end else begin
      svc_state       <= svc_next;
      svc_cnt         <= svc_cnt_d;
      svc_id_o        <= svc_id_d;
      svc_count_o     <= svc_count_d;
      intr_serviced_o <= intr_serviced_d;
      svc_active_o    <= svc_active_d;
    end
  end

endmodule

// File: rtl/intr_host_master.sv
// Host-side master: turns valid/ready register commands into APB-style
// priority-register transfers and runs the interrupt-service handshake.
module intr_host_master
  import intr_host_pkg::*;
#(
  parameter int NUM_INTR   = DEF_NUM_INTR,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int SVC_CYCLES = DEF_SVC_CYCLES
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [ADDR_W-1:0]    cmd_addr_i,
  input  logic [DATA_W-1:0]    cmd_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DATA_W-1:0]    rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [ADDR_W-1:0]    paddr_o,
  output logic [DATA_W-1:0]    pwdata_o,
  output logic                 pwrite_o,
  output logic                 penable_o,
  input  logic [DATA_W-1:0]    prdata_i,
  input  logic                 pready_i,
  input  logic                 perror_i,
  input  logic                 intr_req_i,
  input  logic [INTR_ID_W-1:0] intr_to_service_i,
  output logic                 intr_serviced_o,
  output logic                 svc_active_o,
  output logic [INTR_ID_W-1:0] svc_id_o,
  output logic [15:0]          svc_count_o
);

  localparam int              TO_W       = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_INTR);

  bus_state_e        bus_state, bus_next;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_error_d, pwrite_d, penable_d;
  logic [DATA_W-1:0] rsp_rdata_d, pwdata_d;
  logic [ADDR_W-1:0] paddr_d;

  // Every output is registered, so each one is derived from the next state.
  always_comb begin
    bus_next    = bus_state;
    to_cnt_d    = to_cnt;
    paddr_d     = paddr_o;
    pwdata_d    = pwdata_o;
    pwrite_d    = pwrite_o;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    case (bus_state)
      B_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          if ({1'b0, cmd_addr_i} >= ADDR_LIMIT) begin
            bus_next    = B_RESP;
            rsp_error_d = 1'b1;
          end else begin
            bus_next = B_SETUP;
            paddr_d  = cmd_addr_i;
            pwdata_d = cmd_wdata_i;
            pwrite_d = cmd_write_i;
          end
        end
      end
      B_SETUP: begin
        bus_next = B_ACCESS;
        to_cnt_d = '0;
      end
      B_ACCESS: begin
        if (pready_i) begin
          bus_next    = B_RESP;
          rsp_error_d = perror_i;
          if (!pwrite_o && !perror_i) rsp_rdata_d = prdata_i;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          bus_next    = B_RESP;
          rsp_error_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end
      default: bus_next = B_IDLE;
    endcase
    cmd_ready_d = (bus_next == B_IDLE);
    penable_d   = (bus_next == B_ACCESS);
    rsp_valid_d = (bus_next == B_RESP);
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      bus_state   <= B_IDLE;
      to_cnt      <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pwrite_o    <= 1'b0;
      penable_o   <= 1'b0;
    end else begin
      bus_state   <= bus_next;
      to_cnt      <= to_cnt_d;
      cmd_ready_o <= cmd_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
      rsp_error_o <= rsp_error_d;
      paddr_o     <= paddr_d;
      pwdata_o    <= pwdata_d;
      pwrite_o    <= pwrite_d;
      penable_o   <= penable_d;
    end
  end

  intr_svc_seq #(
    .SVC_CYCLES(SVC_CYCLES)
  ) u_svc_seq (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .intr_req_i        (intr_req_i),
    .intr_to_service_i (intr_to_service_i),
    .intr_serviced_o   (intr_serviced_o),
    .svc_active_o      (svc_active_o),
    .svc_id_o          (svc_id_o),
    .svc_count_o       (svc_count_o)
  );

endmodule

// File: tb/tb_intr_host_master.sv
// Randomised bench for intr_host_master: a memory-backed slave with chosen
// latency/error, a transaction-level bus expectation and a service timeline model.
module tb_intr_host_master;

  localparam int NUM_INTR   = 16;
  localparam int TIMEOUT    = 16;
  localparam int SVC_CYCLES = 4;

  logic       pclk_i, prst_i;
  logic       cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [7:0] cmd_addr_i, cmd_wdata_i;
  logic       rsp_valid_o, rsp_error_o;
  logic [7:0] rsp_rdata_o;
  logic [7:0] paddr_o, pwdata_o, prdata_i;
  logic       pwrite_o, penable_o, pready_i, perror_i;
  logic       intr_req_i, intr_serviced_o, svc_active_o;
  logic [3:0] intr_to_service_i, svc_id_o;
  logic [15:0] svc_count_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] slvMem [0:15];
  logic [7:0] expMem [0:15];
  int   slvLat = 1;
  logic slvErr = 1'b0;
  int   nAccess = 0;
  int   svcMode = 0;

  int         capCyc = -1, ackCyc = -1, eligible = 0;
  logic [3:0] expId = '0;
  logic [15:0] expCount = '0;

  intr_host_master #(
    .NUM_INTR(NUM_INTR), .ADDR_W(8), .DATA_W(8),
    .TIMEOUT(TIMEOUT), .SVC_CYCLES(SVC_CYCLES)
  ) dut (
    .pclk_i(pclk_i), .prst_i(prst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .perror_i(perror_i),
    .intr_req_i(intr_req_i), .intr_to_service_i(intr_to_service_i),
    .intr_serviced_o(intr_serviced_o), .svc_active_o(svc_active_o),
    .svc_id_o(svc_id_o), .svc_count_o(svc_count_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;
  always @(posedge pclk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bus"}, 64'({cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
                                   paddr_o, pwdata_o, pwrite_o, penable_o}), 64'd0);
    checkOutput({tag, "_svc"}, 64'({intr_serviced_o, svc_active_o, svc_id_o, svc_count_o}), 64'd0);
  endtask

  // Slave: answers pready after slvLat extra access cycles (never if too large).
  always @(negedge pclk_i) begin
    if (prst_i || !penable_o) begin
      nAccess  = 0;
      pready_i = 1'b0;
      perror_i = 1'b0;
      prdata_i = 8'h5A;
    end else begin
      nAccess++;
      pready_i = (nAccess == slvLat + 1);
      perror_i = pready_i && slvErr;
      prdata_i = 8'h5A;
      if (pready_i) begin
        if (pwrite_o && !slvErr && paddr_o < 8'(NUM_INTR)) slvMem[paddr_o[3:0]] = pwdata_o;
        prdata_i = slvErr ? 8'hEE : slvMem[paddr_o[3:0]];
      end
    end
  end

  // Interrupt request generator: 0 = quiet, 1 = random, other = held high with ID 5.
  always @(posedge pclk_i) begin
    #2;
    case (svcMode)
      0: intr_req_i = 1'b0;
      1: begin
        intr_req_i        = ($urandom_range(0, 3) != 0);
        intr_to_service_i = 4'($urandom_range(0, 15));
      end
      default: begin
        intr_req_i        = 1'b1;
        intr_to_service_i = 4'd5;
      end
    endcase
  end

  // Service timeline model: capture when idle, ack SVC_CYCLES+1 cycles later, one gap cycle.
  always @(negedge pclk_i) begin
    if (prst_i) begin
      checkOutput("svc_in_reset", 64'({intr_serviced_o, svc_active_o, svc_id_o, svc_count_o}), 64'd0);
      capCyc = -1; ackCyc = -1; eligible = 0; expId = '0; expCount = '0;
    end else begin
      if (cyc == ackCyc && expCount != 16'hFFFF) expCount = expCount + 16'd1;
      checkOutput("intr_serviced", 64'(intr_serviced_o), 64'(cyc == ackCyc));
      checkOutput("svc_active", 64'(svc_active_o), 64'(cyc >= capCyc && cyc < ackCyc));
      checkOutput("svc_id", 64'(svc_id_o), 64'(expId));
      checkOutput("svc_count", 64'(svc_count_o), 64'(expCount));
      if (cyc >= eligible && intr_req_i) begin
        capCyc   = cyc + 1;
        ackCyc   = capCyc + SVC_CYCLES + 1;
        eligible = ackCyc + 2;
        expId    = intr_to_service_i;
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                               input int lat, input logic err);
    int expK, expPen, gotK, penCnt, waitCnt;
    logic expErr, gotErr, busOk, inRange;
    logic [7:0] expData, gotData;
    slvLat = lat;
    slvErr = err;
    waitCnt = 0;
    @(negedge pclk_i);
    while (!cmd_ready_o && waitCnt < 50) begin
      @(negedge pclk_i);
      waitCnt++;
    end
    checkOutput("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd;
    @(posedge pclk_i);
    #1 cmd_valid_i = 1'b0;

    inRange = (addr < 8'(NUM_INTR));
    if (!inRange) begin
      expK = 1; expPen = 0; expErr = 1'b1; expData = 8'h00;
    end else if (lat < TIMEOUT) begin
      expK = 3 + lat; expPen = lat + 1; expErr = err;
      expData = (!wr && !err) ? expMem[addr[3:0]] : 8'h00;
    end else begin
      expK = 2 + TIMEOUT; expPen = TIMEOUT; expErr = 1'b1; expData = 8'h00;
    end

    gotK = 0; penCnt = 0; busOk = 1'b1; gotErr = 1'b0; gotData = 8'h00;
    for (int k = 1; k <= 40 && gotK == 0; k++) begin
      @(negedge pclk_i);
      if (penable_o) penCnt++;
      if (inRange && (k == 1 || penable_o))
        if (paddr_o !== addr || pwrite_o !== wr || (wr && pwdata_o !== wd)) busOk = 1'b0;
      if (rsp_valid_o) begin
        gotK = k; gotErr = rsp_error_o; gotData = rsp_rdata_o;
      end
    end
    checkOutput("rsp_latency", 64'(gotK), 64'(expK));
    checkOutput("rsp_error", 64'(gotErr), 64'(expErr));
    checkOutput("rsp_rdata", 64'(gotData), 64'(expData));
    checkOutput("penable_cycles", 64'(penCnt), 64'(expPen));
    checkOutput("bus_signals", 64'(busOk), 64'd1);
    @(negedge pclk_i);
    checkOutput("rsp_one_cycle", 64'(rsp_valid_o), 64'd0);
    checkOutput("ready_after_rsp", 64'(cmd_ready_o), 64'd1);
    if (wr && inRange && !expErr) expMem[addr[3:0]] = wd;
  endtask

  initial begin
    int n;
    logic [7:0] a;
    int r;
    for (int i = 0; i < 16; i++) begin
      slvMem[i] = 8'h00;
      expMem[i] = 8'h00;
    end
    prst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    intr_req_i = 1'b0; intr_to_service_i = '0;
    pready_i = 1'b0; perror_i = 1'b0; prdata_i = '0;

    repeat (3) @(posedge pclk_i);
    #1 checkAllZero("reset");
    @(posedge pclk_i);
    #2 prst_i = 1'b0;
    @(posedge pclk_i);
    @(negedge pclk_i);
    checkOutput("ready_after_release", 64'(cmd_ready_o), 64'd1);

    svcMode = 2;
    applyStimulus(1'b1, 8'd3, 8'h0A, 1, 1'b0);
    applyStimulus(1'b0, 8'd3, 8'h00, 1, 1'b0);
    applyStimulus(1'b0, 8'd16, 8'h00, 1, 1'b0);
    applyStimulus(1'b1, 8'd7, 8'h33, 20, 1'b0);
    applyStimulus(1'b0, 8'd5, 8'h00, 0, 1'b1);
    applyStimulus(1'b0, 8'd7, 8'h00, 0, 1'b0);
    applyStimulus(1'b1, 8'd15, 8'hC3, 15, 1'b0);
    applyStimulus(1'b0, 8'd15, 8'h00, 2, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'h99, 0, 1'b0);

    svcMode = 1;
    for (int t = 0; t < 60; t++) begin
      a = 8'($urandom_range(0, 19));
      r = int'($urandom_range(0, 9));
      applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                    (r == 9) ? 20 : r % 4, ($urandom_range(0, 9) == 0));
    end

    svcMode = 2;
    slvLat = 20;
    slvErr = 1'b0;
    n = 0;
    @(negedge pclk_i);
    while (!cmd_ready_o && n < 50) begin
      @(negedge pclk_i);
      n++;
    end
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'd2;
    @(posedge pclk_i);
    #1 cmd_valid_i = 1'b0;
    n = 0;
    @(negedge pclk_i);
    while (!(penable_o && svc_active_o) && n < 40) begin
      @(negedge pclk_i);
      n++;
    end
    checkOutput("mid_access_and_busy", 64'(penable_o && svc_active_o), 64'd1);
    svcMode = 0;
    #3 prst_i = 1'b1;
    #1 checkAllZero("mid_reset");
    repeat (3) @(posedge pclk_i);
    #2 prst_i = 1'b0;
    @(posedge pclk_i);
    @(negedge pclk_i);
    checkOutput("ready_after_mid_reset", 64'(cmd_ready_o), 64'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk_i);
      checkOutput("no_rsp_after_reset", 64'({rsp_valid_o, penable_o, intr_serviced_o}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_host_master.md
Name: intr_host_master

Overview:
- Processor-side counterpart of the interrupt controller.
- Takes register read/write commands from a simple valid/ready command port and drives them onto the controller's APB-style priority-register bus (paddr/pwdata/pwrite/penable/pready/perror).
- Independently runs the interrupt-service handshake: captures the interrupt ID presented by the controller, emulates a handler for SVC_CYCLES cycles, then pulses intr_serviced_o.
- Used as the host model in subsystem integration and as a synthesizable bring-up master.

Parameters:
NUM_INTR, 16, number of priority registers; legal addresses are 0..NUM_INTR-1
ADDR_W, 8, bus address width
DATA_W, 8, bus data width
TIMEOUT, 16, maximum ACCESS cycles to wait for pready_i before aborting
SVC_CYCLES, 4, handler busy time in cycles between interrupt capture and acknowledge (0 legal)

Ports:
pclk_i  in  1  clock, rising edge
prst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when high with cmd_valid_i
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  register index
cmd_wdata_i  in  DATA_W  write data
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DATA_W  read data, 0 on write or error
rsp_error_o  out  1  error flag, qualified by rsp_valid_o
paddr_o  out  ADDR_W  bus address
pwdata_o  out  DATA_W  bus write data
pwrite_o  out  1  bus direction
penable_o  out  1  bus access phase
prdata_i  in  DATA_W  bus read data
pready_i  in  1  bus transfer complete
perror_i  in  1  bus slave error
intr_req_i  in  1  controller has an interrupt outstanding
intr_to_service_i  in  4  ID of the interrupt to service
intr_serviced_o  out  1  one-cycle acknowledge to controller
svc_active_o  out  1  handler busy
svc_id_o  out  4  ID latched at capture
svc_count_o  out  16  serviced-interrupt count, saturating at 0xFFFF

Behaviour:
- Reset (async, any state): all outputs 0, including cmd_ready_o; both FSMs go to idle; an in-flight transfer or service is dropped with no response and no ack. First cycle after reset release: cmd_ready_o=1.
- All outputs are registered.
- Bus FSM, states B_IDLE, B_SETUP, B_ACCESS, B_RESP:
  - B_IDLE: cmd_ready_o=1, penable_o=0.
  - On cmd_valid_i & cmd_ready_o, capture addr/write/wdata.
  - If addr >= NUM_INTR: go to B_RESP with error=1; no bus activity.
  - Otherwise go to B_SETUP.
  - B_SETUP (1 cycle): paddr_o/pwrite_o/pwdata_o driven, penable_o=0, then B_ACCESS.
  - B_ACCESS: penable_o=1; bus signals held stable.
  - In B_ACCESS, on pready_i=1: capture prdata_i (reads only) and perror_i, go to B_RESP.
  - A timeout counter starts at 0 on entry to B_ACCESS. If it reaches TIMEOUT with no pready_i, go to B_RESP with error=1, rdata=0.
  - Leaving B_ACCESS: penable_o=0 on the next cycle.
  - B_RESP: rsp_valid_o=1 for exactly one cycle, then B_IDLE. cmd_ready_o=0 in every state except B_IDLE.
  - Minimum latency with pready_i returned the cycle after penable: accept at T, setup T+1, access T+2, pready T+3, rsp_valid T+4.
  - Back-to-back: the next command can be accepted the cycle after rsp_valid_o.
  - Between transfers, paddr_o/pwdata_o/pwrite_o hold their last values.
- Service FSM, states S_IDLE, S_BUSY, S_ACK, S_GAP; independent of the bus FSM, so both may be active in the same cycle:
  - S_IDLE: on intr_req_i=1, latch intr_to_service_i into svc_id_o, set svc_active_o=1, load the countdown with SVC_CYCLES, go to S_BUSY.
  - S_BUSY: decrement each cycle; at 0 go to S_ACK. With SVC_CYCLES=0 this is S_BUSY for 1 cycle.
  - S_ACK: intr_serviced_o=1 for one cycle; svc_count_o increments unless already 0xFFFF; svc_active_o clears.
  - S_GAP: one mandatory cycle ignoring intr_req_i, giving the controller time to drop or update its request; then S_IDLE.
  - Changes to intr_to_service_i after capture are ignored until the next capture.
  - Deassertion of intr_req_i during S_BUSY does not abort; the ack is still issued.

Decomposition:
- Package intr_host_pkg holds:
  - bus FSM state encodings
  - service FSM state encodings
  - default NUM_INTR/TIMEOUT/SVC_CYCLES constants
  - the 4-bit interrupt ID width
- Natural sub-module: intr_svc_seq, the service FSM plus counter, instantiated once. Bus FSM lives in the top.

Test Plan:
- Write: cmd addr=3 wdata=0x0A, slave pready one cycle after penable -> paddr_o=3, pwdata_o=0x0A, pwrite_o=1 in SETUP and ACCESS; rsp_valid_o at T+4 with error=0, rdata=0.
- Read-back: read addr=3, slave returns 0x0A -> rsp_rdata_o=0x0A, error=0. Then read addr=16 -> rsp_valid_o at T+1, error=1, penable_o never asserted.
- Timeout: slave never asserts pready_i -> penable_o high exactly 16 cycles, then rsp_valid_o with error=1, rdata=0. Separately, perror_i=1 with pready_i -> error=1.
- Service: intr_req_i=1, ID=5, SVC_CYCLES=4 -> svc_id_o=5, svc_active_o high; intr_serviced_o pulses once 5 cycles after capture; svc_count_o goes 0->1. With intr_req_i held high, the next capture occurs only after the S_GAP cycle.
- Concurrency/reset: a service in flight during a read transfer -> both complete with correct timing. Assert prst_i mid-ACCESS and mid-S_BUSY -> all outputs 0 immediately; no rsp_valid_o or intr_serviced_o after release; cmd_ready_o=1 on the first cycle after release.
